icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have no parameters; geometry fixed: 2 ways, 256 sets, 16-byte line (4 x 32-bit words), 20-bit tag.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  in  1  fetch request from IF.
REQ-005 req_ready  out  1  icache can accept a request this cycle.
REQ-006 inst_tag  in  20  physical tag from MMU (paddr[31:12]).
REQ-007 inst_index  in  8  set index from MMU (paddr[11:4]).
REQ-008 inst_offset  in  4  byte offset from MMU (paddr[3:0]); [1:0] ignored.
REQ-009 flush  in  1  redirect; cancels outstanding request response.
REQ-010 resp_valid  out  1  one-cycle pulse, instruction valid; no backpressure.
REQ-011 resp_inst  out  32  fetched instruction word.
REQ-012 rd_req  out  1  line refill request to memory bus.
REQ-013 rd_addr  out  32  refill address {tag,index,4'b0}.
REQ-014 rd_rdy  in  1  bus accepts rd_req.
REQ-015 ret_valid  in  1  refill data beat valid.
REQ-016 ret_last  in  1  final refill beat.
REQ-017 ret_data  in  32  refill data, word 0 first, ascending.

Function
REQ-018 States SHALL be IDLE, LOOKUP, MISS, REFILL, REPLAY.
REQ-019 req_ready SHALL be 1 in IDLE, and in LOOKUP on hit; 0 elsewhere and 0 whenever flush=1.
REQ-020 On req_valid&&req_ready, tag/index/offset SHALL be latched and state SHALL be LOOKUP next cycle.
REQ-021 LOOKUP hit (valid && tag match in either way): resp_valid=1 and resp_inst=word offset[3:2] in that cycle (1-cycle latency from acceptance); LRU for set SHALL mark hit way most-recent; next state LOOKUP if new request accepted, else IDLE.
REQ-022 LOOKUP miss: next state MISS; no response.
REQ-023 MISS: rd_req=1, rd_addr stable until rd_rdy; on rd_req&&rd_rdy go REFILL.
REQ-024 REFILL: each ret_valid beat SHALL store into line buffer at 2-bit beat counter, counter increments and wraps 3->0; ret_last SHALL end refill.
REQ-025 On ret_last, line SHALL be written to victim way: way0 if invalid, else way1 if invalid, else LRU way; set valid, mark victim most-recent; next state REPLAY.
REQ-026 REPLAY: resp_valid=1 with requested word from line buffer (bypass), then IDLE.
REQ-027 Flush in LOOKUP SHALL suppress resp_valid and go IDLE; flush in MISS/REFILL SHALL set cancel flag; refill completes and line is written but REPLAY response suppressed; cancel cleared on IDLE entry.
REQ-028 rd_req SHALL never deassert before rd_rdy, including under flush.
REQ-029 Hit in both ways (illegal) SHALL select way0.
REQ-030 resp_inst SHALL be 0 whenever resp_valid=0.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, all 512 valid bits 0, all LRU bits 0, cancel 0, beat counter 0, all outputs 0 except req_ready which is 1 only after reset release.
REQ-032 Reset during MISS/REFILL SHALL abandon refill; rd_req deasserts asynchronously; no line is written.

Configuration
REQ-033 With ICACHE_PERF_CNT_EN defined, outputs hit_cnt and miss_cnt (32 bits each, wrapping, reset 0) SHALL count LOOKUP hits and LOOKUP misses, flushed lookups included; without it these ports and counters SHALL not exist and behaviour is otherwise identical.

Verification
REQ-034 Cold fetch tag=0x1C000, index=0x00, offset=0x4; beats 0xA0..0xA3 -> rd_addr=0x1C000000, resp_inst=0xA1 in REPLAY.
REQ-035 Refetch same line, offset=0xC -> resp_valid next cycle, resp_inst=0xA3, no rd_req.
REQ-036 Three different tags to index 0x05 -> third miss evicts LRU way; refetch of evicted tag misses.
REQ-037 Flush during REFILL -> no resp_valid; later fetch of that line hits.
REQ-038 rst_n low mid-REFILL -> rd_req=0 immediately; after release same address misses.
REQ-039 Back-to-back hits on 4 consecutive cycles -> 4 consecutive resp_valid pulses, req_ready held 1.

Source files
------------

// File: rtl/icache.sv
// Two-way, 256-set, 16-byte-line blocking instruction cache with line-buffer replay.
// Define ICACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt lookup counters.
module icache (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [19:0] inst_tag,
  input  logic [7:0]  inst_index,
  input  logic [3:0]  inst_offset,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_inst,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
`ifdef ICACHE_PERF_CNT_EN
  input  logic [31:0] ret_data,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`else
  input  logic [31:0] ret_data
`endif
);

  typedef enum logic [2:0] {StIdle, StLookup, StMiss, StRefill, StReplay} state_e;

  state_e                 state_q;
  logic [19:0]            tag_q;
  logic [7:0]             index_q;
  logic [1:0]             off_q;
  logic [1:0]             cnt_q;
  logic                   cancel_q;
  logic                   rd_req_q;
  logic [1:0][255:0]      valid_q;
  logic [255:0]           lru_q;     // per set: the least-recently-used way
  logic [3:0][31:0]       line_q;

  logic [19:0]            tag_mem  [2][256];
  logic [3:0][31:0]       data_mem [2][256];

  logic                   hit0, hit1, any_hit, lookup_hit, accept, victim, fill_done;
  logic [3:0][31:0]       hit_line, line_new;
  logic                   unused_offset;

  assign unused_offset = ^inst_offset[1:0];

  // Way0 wins when both ways claim a hit.
  assign hit0       = valid_q[0][index_q] && (tag_mem[0][index_q] == tag_q);
  assign hit1       = valid_q[1][index_q] && (tag_mem[1][index_q] == tag_q);
  assign any_hit    = hit0 || hit1;
  assign lookup_hit = (state_q == StLookup) && any_hit;
  assign hit_line   = hit0 ? data_mem[0][index_q] : data_mem[1][index_q];

  assign req_ready  = rst_n && !flush && ((state_q == StIdle) || lookup_hit);
  assign accept     = req_valid && req_ready;

  assign victim     = !valid_q[0][index_q] ? 1'b0 :
                      !valid_q[1][index_q] ? 1'b1 : lru_q[index_q];
  assign fill_done  = (state_q == StRefill) && ret_valid && ret_last;

  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_req_q ? {tag_q, index_q, 4'b0000} : 32'd0;

  always_comb begin
    line_new        = line_q;
    line_new[cnt_q] = ret_data;
  end

  always_comb begin
    resp_valid = 1'b0;
    resp_inst  = 32'd0;
    if (lookup_hit && !flush) begin
      resp_valid = 1'b1;
      resp_inst  = hit_line[off_q];
    end else if ((state_q == StReplay) && !cancel_q && !flush) begin
      resp_valid = 1'b1;
      resp_inst  = line_q[off_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      tag_q    <= '0;
      index_q  <= '0;
      off_q    <= '0;
      cnt_q    <= '0;
      cancel_q <= 1'b0;
      rd_req_q <= 1'b0;
      valid_q  <= '0;
      lru_q    <= '0;
      line_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cancel_q <= 1'b0;
          if (accept) begin
            tag_q   <= inst_tag;
            index_q <= inst_index;
            off_q   <= inst_offset[3:2];
            state_q <= StLookup;
          end
        end
        StLookup: begin
          if (flush) begin
            state_q <= StIdle;
          end else if (any_hit) begin
            lru_q[index_q] <= hit0;
            if (accept) begin
              tag_q   <= inst_tag;
              index_q <= inst_index;
              off_q   <= inst_offset[3:2];
            end else begin
              state_q <= StIdle;
            end
          end else begin
            rd_req_q <= 1'b1;
            state_q  <= StMiss;
          end
        end
        StMiss: begin
          if (flush) cancel_q <= 1'b1;
          if (rd_rdy) begin
            rd_req_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= StRefill;
          end
        end
        StRefill: begin
          if (flush) cancel_q <= 1'b1;
          if (ret_valid) begin
            line_q <= line_new;
            cnt_q  <= cnt_q + 2'd1;
            if (ret_last) begin
              valid_q[victim][index_q] <= 1'b1;
              lru_q[index_q]           <= ~victim;
              state_q                  <= StReplay;
            end
          end
        end
        StReplay: begin
          cancel_q <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Arrays carry no reset; a reset mid-refill drops state to idle so nothing is written.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[victim][index_q]  <= tag_q;
      data_mem[victim][index_q] <= line_new;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_q == StLookup) begin
      if (any_hit) hit_cnt  <= hit_cnt + 32'd1;
      else         miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold misses, hits, LRU eviction, flush and reset mid-refill.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] inst_tag;
  logic [7:0]  inst_index;
  logic [3:0]  inst_offset;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  icache dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .inst_tag    (inst_tag),
    .inst_index  (inst_index),
    .inst_offset (inst_offset),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_inst   (resp_inst),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_rdy      (rd_rdy),
    .ret_valid   (ret_valid),
    .ret_last    (ret_last),
`ifdef ICACHE_PERF_CNT_EN
    .ret_data    (ret_data),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`else
    .ret_data    (ret_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Accept a request that must miss; returns at negedge+1 with MISS state and rd_req high.
  task automatic start_miss(input logic [19:0] t, input logic [7:0] idx, input logic [3:0] off);
    @(negedge clk);
    req_valid = 1'b1; inst_tag = t; inst_index = idx; inst_offset = off;
    #1 check("miss_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("lookup_miss_no_resp", 32'(resp_valid), 32'd0);
    check("lookup_miss_inst_zero", resp_inst, 32'd0);
    @(negedge clk);
    #1;
    check("miss_rd_req", 32'(rd_req), 32'd1);
    check("miss_rd_addr", rd_addr, {t, idx, 4'b0000});
  endtask

  task automatic finish_refill(input logic [31:0] base, input logic [31:0] exp_inst,
                               input logic do_flush);
    logic [31:0] addr_hold;
    addr_hold = rd_addr;
    @(negedge clk);
    #1;
    check("rd_req_held", 32'(rd_req), 32'd1);
    check("rd_addr_stable", rd_addr, addr_hold);
    rd_rdy = 1'b1;
    @(negedge clk);
    rd_rdy = 1'b0;
    #1 check("rd_req_drop_after_rdy", 32'(rd_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      ret_valid = 1'b1;
      ret_data  = base + 32'(i);
      ret_last  = (i == 3);
      flush     = do_flush && (i == 1);
      @(negedge clk);
      #1;
    end
    ret_valid = 1'b0; ret_last = 1'b0; flush = 1'b0;
    #1;
    check("replay_resp_valid", 32'(resp_valid), do_flush ? 32'd0 : 32'd1);
    check("replay_resp_inst", resp_inst, do_flush ? 32'd0 : exp_inst);
    @(negedge clk);
    #1;
    check("post_replay_idle_ready", 32'(req_ready), 32'd1);
    check("post_replay_no_resp", 32'(resp_valid), 32'd0);
  endtask

  task automatic fetch_hit(input logic [19:0] t, input logic [7:0] idx, input logic [3:0] off,
                           input logic [31:0] exp_inst);
    @(negedge clk);
    req_valid = 1'b1; inst_tag = t; inst_index = idx; inst_offset = off;
    #1 check("hit_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("hit_resp_valid", 32'(resp_valid), 32'd1);
    check("hit_resp_inst", resp_inst, exp_inst);
    check("hit_no_rd_req", 32'(rd_req), 32'd0);
    @(negedge clk);
    #1 check("hit_then_idle_no_rd_req", 32'(rd_req), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; inst_tag = '0; inst_index = '0; inst_offset = '0;
    flush = 1'b0; rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_rd_addr", rd_addr, 32'd0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    #1 check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Cold fetch then refetch of the same line.
    start_miss(20'h1C000, 8'h00, 4'h4);
    check("cold_rd_addr", rd_addr, 32'h1C00_0000);
    finish_refill(32'hA0, 32'hA1, 1'b0);
    fetch_hit(20'h1C000, 8'h00, 4'hC, 32'hA3);

    // LRU: 0x22 becomes LRU after 0x11 is re-hit, so 0x33 evicts 0x22.
    start_miss(20'h00011, 8'h05, 4'h0); finish_refill(32'hB0, 32'hB0, 1'b0);
    start_miss(20'h00022, 8'h05, 4'h4); finish_refill(32'hC0, 32'hC1, 1'b0);
    fetch_hit(20'h00011, 8'h05, 4'h4, 32'hB1);
    start_miss(20'h00033, 8'h05, 4'h8); finish_refill(32'hD0, 32'hD2, 1'b0);
    fetch_hit(20'h00011, 8'h05, 4'h8, 32'hB2);
    fetch_hit(20'h00033, 8'h05, 4'h0, 32'hD0);
    start_miss(20'h00022, 8'h05, 4'hC); finish_refill(32'hE0, 32'hE3, 1'b0);

    // Flush during refill suppresses the replay but the line is kept.
    start_miss(20'h00044, 8'h09, 4'h4); finish_refill(32'hF0, 32'hF1, 1'b1);
    fetch_hit(20'h00044, 8'h09, 4'h4, 32'hF1);

    // Flush in LOOKUP suppresses a hit response.
    @(negedge clk);
    req_valid = 1'b1; inst_tag = 20'h00044; inst_index = 8'h09; inst_offset = 4'h0;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    #1;
    check("flush_lookup_no_resp", 32'(resp_valid), 32'd0);
    check("flush_lookup_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1 check("flush_lookup_idle", 32'(req_ready), 32'd1);

    // Reset while rd_req is high drops it asynchronously.
    start_miss(20'h00066, 8'h11, 4'h0);
    rst_n = 1'b0;
    #1 check("rst_in_miss_rd_req", 32'(rd_req), 32'd0);
    #3 rst_n = 1'b1;

    // Reset mid-refill: no line written, and prior lines invalidated.
    start_miss(20'h00055, 8'h10, 4'h8);
    rd_rdy = 1'b1;
    @(negedge clk);
    rd_rdy = 1'b0;
    ret_valid = 1'b1; ret_data = 32'h50;
    @(negedge clk);
    ret_data = 32'h51;
    #1 rst_n = 1'b0;
    ret_valid = 1'b0;
    #1;
    check("rst_refill_rd_req", 32'(rd_req), 32'd0);
    check("rst_refill_resp", 32'(resp_valid), 32'd0);
    #3 rst_n = 1'b1;
    start_miss(20'h00055, 8'h10, 4'h8); finish_refill(32'h60, 32'h62, 1'b0);
    start_miss(20'h1C000, 8'h00, 4'h0); finish_refill(32'h90, 32'h90, 1'b0);

    // Four back-to-back hits.
    start_miss(20'h00077, 8'h20, 4'h0); finish_refill(32'h70, 32'h70, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid   = (i < 4);
      inst_tag    = 20'h00077;
      inst_index  = 8'h20;
      inst_offset = 4'(i * 4);
      #1;
      if (i < 4) check("b2b_req_ready", 32'(req_ready), 32'd1);
      if (i > 0) begin
        check("b2b_resp_valid", 32'(resp_valid), 32'd1);
        check("b2b_resp_inst", resp_inst, 32'h70 + 32'(i - 1));
      end
    end
    @(negedge clk);
    #1 check("b2b_end_no_resp", 32'(resp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
